// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue
//   Buffers FPU ops issued from the E stage in an in-order FIFO and dispatches
//   them to the FPU datapath under valid/ready, with at most INFLIGHT ops
//   outstanding. Destination registers of queued and outstanding ops are
//   reported back to the hazard logic as pending; results come back as a
//   registered write-back port.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   enq_*                    op issued from E (enq_valid already qualified)
//   full                     issue FIFO holds DEPTH entries
//   Rs1E, Rs2E               E-stage sources checked against pending rds
//   operand_invalid1/2       source still pending in queue or FPU
//   fpu_req_*                dispatch request to the FPU (valid/ready)
//   fpu_resp_valid/data      FPU results, in dispatch order
//   RegWriteW_fpu, RdW_fpu,
//   ResultW_fpu              write-back port, one cycle after a response
//   overflow_err             sticky: enqueue while full, or orphan response
//
// Configuration
//   FPU_BYPASS_EN            when defined, an op arriving at an empty FIFO is
//                            offered to the FPU in the same cycle.

module fpu_issue_queue #(
  parameter int DEPTH    = 4,
  parameter int INFLIGHT = 4,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enq_valid,
  input  logic [5:0]      enq_rd,
  input  logic [4:0]      enq_funct,
  input  logic [XLEN-1:0] enq_src1,
  input  logic [XLEN-1:0] enq_src2,
  output logic            full,
  input  logic [5:0]      Rs1E,
  input  logic [5:0]      Rs2E,
  output logic            operand_invalid1,
  output logic            operand_invalid2,
  output logic            fpu_req_valid,
  input  logic            fpu_req_ready,
  output logic [4:0]      fpu_req_funct,
  output logic [XLEN-1:0] fpu_req_a,
  output logic [XLEN-1:0] fpu_req_b,
  input  logic            fpu_resp_valid,
  input  logic [XLEN-1:0] fpu_resp_data,
  output logic            RegWriteW_fpu,
  output logic [5:0]      RdW_fpu,
  output logic [XLEN-1:0] ResultW_fpu,
  output logic            overflow_err
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int IW  = (INFLIGHT > 1) ? $clog2(INFLIGHT) : 1;
  localparam int ICW = $clog2(INFLIGHT) + 1;

  // Issue FIFO storage; a per-entry valid bit makes the pending scan simple.
  logic [5:0]      fifo_rd    [DEPTH];
  logic [4:0]      fifo_funct [DEPTH];
  logic [XLEN-1:0] fifo_a     [DEPTH];
  logic [XLEN-1:0] fifo_b     [DEPTH];
  logic [DEPTH-1:0] fifo_vld;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  // Destination registers of ops handed to the FPU, oldest at if_rd_ptr.
  logic [5:0]        if_rd [INFLIGHT];
  logic [INFLIGHT-1:0] if_vld;
  logic [IW-1:0]     if_wr_ptr, if_rd_ptr;
  logic [ICW-1:0]    if_count;

  logic [5:0] wb_rd;
  logic       wb_we;

  logic can_issue, bypass, fire, deq, enq_accept, resp_pop;
  logic [5:0] disp_rd;

  assign full      = (count == CW'(DEPTH));
  assign can_issue = (if_count < ICW'(INFLIGHT));

`ifdef FPU_BYPASS_EN
  assign bypass = (count == '0) && can_issue && enq_valid;
`else
  assign bypass = 1'b0;
`endif

  // During bypass the request comes straight from the enq inputs; otherwise
  // the FIFO head is shown and held until the FPU takes it.
  assign fpu_req_valid = ((count != '0) && can_issue) || bypass;
  assign fpu_req_funct = bypass ? enq_funct : fifo_funct[rd_ptr];
  assign fpu_req_a     = bypass ? enq_src1  : fifo_a[rd_ptr];
  assign fpu_req_b     = bypass ? enq_src2  : fifo_b[rd_ptr];
  assign disp_rd       = bypass ? enq_rd    : fifo_rd[rd_ptr];

  assign fire       = fpu_req_valid && fpu_req_ready;
  assign deq        = fire && !bypass;
  // A bypassed op that the FPU accepts never touches the FIFO.
  assign enq_accept = enq_valid && !full && !(bypass && fpu_req_ready);
  assign resp_pop   = fpu_resp_valid && (if_count != '0);

  assign RegWriteW_fpu = wb_we;
  assign RdW_fpu       = wb_rd;

  // Control state: pointers, counts, valid bits, write-back and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      fifo_vld     <= '0;
      if_wr_ptr    <= '0;
      if_rd_ptr    <= '0;
      if_count     <= '0;
      if_vld       <= '0;
      wb_we        <= 1'b0;
      wb_rd        <= '0;
      ResultW_fpu  <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (enq_accept) begin
        fifo_vld[wr_ptr] <= 1'b1;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (deq) begin
        fifo_vld[rd_ptr] <= 1'b0;
        rd_ptr           <= rd_ptr + 1'b1;
      end
      count <= count + CW'(enq_accept) - CW'(deq);

      if (fire) begin
        if_vld[if_wr_ptr] <= 1'b1;
        if_wr_ptr <= (if_wr_ptr == IW'(INFLIGHT - 1)) ? '0 : if_wr_ptr + 1'b1;
      end
      if (resp_pop) begin
        if_vld[if_rd_ptr] <= 1'b0;
        if_rd_ptr <= (if_rd_ptr == IW'(INFLIGHT - 1)) ? '0 : if_rd_ptr + 1'b1;
      end
      if_count <= if_count + ICW'(fire) - ICW'(resp_pop);

      // Register 0 is computed and returned but never written.
      wb_we <= resp_pop && (if_rd[if_rd_ptr] != 6'd0);
      if (resp_pop) begin
        wb_rd       <= if_rd[if_rd_ptr];
        ResultW_fpu <= fpu_resp_data;
      end

      if ((enq_valid && full) || (fpu_resp_valid && (if_count == '0)))
        overflow_err <= 1'b1;
    end
  end

  // Payload storage needs no reset; the valid bits qualify every entry.
  always_ff @(posedge clk) begin
    if (enq_accept) begin
      fifo_rd[wr_ptr]    <= enq_rd;
      fifo_funct[wr_ptr] <= enq_funct;
      fifo_a[wr_ptr]     <= enq_src1;
      fifo_b[wr_ptr]     <= enq_src2;
    end
    if (fire)
      if_rd[if_wr_ptr] <= disp_rd;
  end

  // Pending scan over every live entry; duplicates of one rd keep it pending
  // until the last copy leaves.
  always_comb begin
    operand_invalid1 = 1'b0;
    operand_invalid2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_vld[i] && (fifo_rd[i] == Rs1E)) operand_invalid1 = 1'b1;
      if (fifo_vld[i] && (fifo_rd[i] == Rs2E)) operand_invalid2 = 1'b1;
    end
    for (int j = 0; j < INFLIGHT; j++) begin
      if (if_vld[j] && (if_rd[j] == Rs1E)) operand_invalid1 = 1'b1;
      if (if_vld[j] && (if_rd[j] == Rs2E)) operand_invalid2 = 1'b1;
    end
    if (Rs1E == 6'd0) operand_invalid1 = 1'b0;
    if (Rs2E == 6'd0) operand_invalid2 = 1'b0;
  end

endmodule

// File: tb/tb_fpu_issue_queue.sv
// tb_fpu_issue_queue
//   Directed bench for fpu_issue_queue (DEPTH=4, INFLIGHT=4, XLEN=32).
//   Inputs change 1ns after the rising edge; outputs are sampled in the same
//   window, so registered outputs reflect the edge just taken.

module tb_fpu_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_valid;
  logic [5:0]  enq_rd;
  logic [4:0]  enq_funct;
  logic [31:0] enq_src1, enq_src2;
  logic        full;
  logic [5:0]  Rs1E, Rs2E;
  logic        operand_invalid1, operand_invalid2;
  logic        fpu_req_valid, fpu_req_ready;
  logic [4:0]  fpu_req_funct;
  logic [31:0] fpu_req_a, fpu_req_b;
  logic        fpu_resp_valid;
  logic [31:0] fpu_resp_data;
  logic        RegWriteW_fpu;
  logic [5:0]  RdW_fpu;
  logic [31:0] ResultW_fpu;
  logic        overflow_err;

  int testsRun = 0;
  int testsFailed = 0;
  int dispatches;

  fpu_issue_queue #(.DEPTH(4), .INFLIGHT(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_rd(enq_rd), .enq_funct(enq_funct),
    .enq_src1(enq_src1), .enq_src2(enq_src2), .full(full),
    .Rs1E(Rs1E), .Rs2E(Rs2E),
    .operand_invalid1(operand_invalid1), .operand_invalid2(operand_invalid2),
    .fpu_req_valid(fpu_req_valid), .fpu_req_ready(fpu_req_ready),
    .fpu_req_funct(fpu_req_funct), .fpu_req_a(fpu_req_a), .fpu_req_b(fpu_req_b),
    .fpu_resp_valid(fpu_resp_valid), .fpu_resp_data(fpu_resp_data),
    .RegWriteW_fpu(RegWriteW_fpu), .RdW_fpu(RdW_fpu), .ResultW_fpu(ResultW_fpu),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  // One comparison: count it and report a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive the enqueue port for the coming edge.
  task automatic applyStimulus(input logic v, input logic [5:0] rd, input logic [4:0] fn,
                               input logic [31:0] a, input logic [31:0] b);
    enq_valid = v;
    enq_rd    = rd;
    enq_funct = fn;
    enq_src1  = a;
    enq_src2  = b;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic respond(input logic [31:0] data);
    fpu_resp_valid = 1'b1;
    fpu_resp_data  = data;
    step();
    fpu_resp_valid = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    fpu_req_ready = 1'b0;
    fpu_resp_valid = 1'b0;
    fpu_resp_data = '0;
    Rs1E = 6'd5;
    Rs2E = 6'd0;
    applyStimulus(0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
    #1;

    // Reset state
    checkOutput("rst_full", full, 0);
    checkOutput("rst_req_valid", fpu_req_valid, 0);
    checkOutput("rst_regwrite", RegWriteW_fpu, 0);
    checkOutput("rst_rdw", RdW_fpu, 0);
    checkOutput("rst_result", ResultW_fpu, 0);
    checkOutput("rst_ovf", overflow_err, 0);
    checkOutput("rst_inv1", operand_invalid1, 0);

    // Single op rd=5 through queue, FPU and write-back
    fpu_req_ready = 1'b1;
    applyStimulus(1, 6'd5, 5'd3, 32'h4000_0000, 32'h4040_0000);
`ifdef FPU_BYPASS_EN
    checkOutput("t1_bypass_valid", fpu_req_valid, 1);
    checkOutput("t1_bypass_a", fpu_req_a, 32'h4000_0000);
    step();
    applyStimulus(0, 0, 0, 0, 0);
`else
    checkOutput("t1_no_same_cycle", fpu_req_valid, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t1_req_valid", fpu_req_valid, 1);
    checkOutput("t1_req_funct", fpu_req_funct, 3);
    checkOutput("t1_req_a", fpu_req_a, 32'h4000_0000);
    checkOutput("t1_req_b", fpu_req_b, 32'h4040_0000);
    checkOutput("t1_inv_queued", operand_invalid1, 1);
    step();
`endif
    fpu_req_ready = 1'b0;
    #1;
    checkOutput("t1_req_idle", fpu_req_valid, 0);
    checkOutput("t1_inv_inflight", operand_invalid1, 1);
    fpu_resp_valid = 1'b1;
    fpu_resp_data  = 32'h3F80_0000;
    #1;
    checkOutput("t1_inv_resp_cycle", operand_invalid1, 1);
    step();
    fpu_resp_valid = 1'b0;
    #1;
    checkOutput("t1_wb_we", RegWriteW_fpu, 1);
    checkOutput("t1_wb_rd", RdW_fpu, 5);
    checkOutput("t1_wb_data", ResultW_fpu, 32'h3F80_0000);
    checkOutput("t1_inv_cleared", operand_invalid1, 0);
    step();
    checkOutput("t1_wb_pulse", RegWriteW_fpu, 0);

    // Fill the FIFO with ready low, then overflow it
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 6'(i + 1), 5'(i + 1), 32'hA0 + i, 32'hB0 + i);
      step();
    end
    checkOutput("t2_full", full, 1);
    checkOutput("t2_req_valid", fpu_req_valid, 1);
    applyStimulus(1, 6'd6, 5'h1F, 32'hDEAD, 32'hBEEF);
    step();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t2_ovf", overflow_err, 1);
    checkOutput("t2_still_full", full, 1);
    checkOutput("t2_head_funct", fpu_req_funct, 1);
    checkOutput("t2_head_a", fpu_req_a, 32'hA0);
    checkOutput("t2_head_b", fpu_req_b, 32'hB0);
    Rs1E = 6'd3;
    Rs2E = 6'd6;
    #1;
    checkOutput("t2_inv_rd3", operand_invalid1, 1);
    checkOutput("t2_inv_dropped", operand_invalid2, 0);

    // Credit limit: only 4 dispatches without responses
    Rs1E = 6'd7;
    Rs2E = 6'd3;
    fpu_req_ready = 1'b1;
    dispatches = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 1) begin
        applyStimulus(1, 6'd7, 5'd7, 32'h70, 32'h71);
        checkOutput("t3_enq_not_pending", operand_invalid1, 0);
      end else begin
        applyStimulus(0, 0, 0, 0, 0);
      end
      if (fpu_req_valid && fpu_req_ready) dispatches++;
      step();
    end
    checkOutput("t3_dispatches", dispatches, 4);
    checkOutput("t3_stalled", fpu_req_valid, 0);
    checkOutput("t3_head_funct", fpu_req_funct, 7);
    checkOutput("t3_inv1_rd7", operand_invalid1, 1);
    checkOutput("t3_inv2_rd3", operand_invalid2, 1);
    respond(32'h1111);
    checkOutput("t3_wb_rd1", RdW_fpu, 1);
    checkOutput("t3_wb_data1", ResultW_fpu, 32'h1111);
    checkOutput("t3_redispatch", fpu_req_valid, 1);
    checkOutput("t3_redispatch_a", fpu_req_a, 32'h70);
    step();
    checkOutput("t3_drained", fpu_req_valid, 0);
    fpu_req_ready = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      respond(32'h1111 * k);
      checkOutput("t3_wb_we", RegWriteW_fpu, 1);
      checkOutput("t3_wb_rd", RdW_fpu, k);
      checkOutput("t3_wb_data", ResultW_fpu, 32'h1111 * k);
      checkOutput("t3_inv1_hold", operand_invalid1, 1);
      if (k == 2) checkOutput("t3_inv2_pre", operand_invalid2, 1);
      if (k == 3) checkOutput("t3_inv2_post", operand_invalid2, 0);
    end
    respond(32'h7777);
    checkOutput("t3_wb_rd7", RdW_fpu, 7);
    checkOutput("t3_wb_data7", ResultW_fpu, 32'h7777);
    checkOutput("t3_inv1_clear", operand_invalid1, 0);

    // rd=0: executed, result returned, never written or pending
    Rs1E = 6'd0;
    applyStimulus(1, 6'd0, 5'd4, 32'h1, 32'h2);
    step();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t4_r0_not_pending", operand_invalid1, 0);
    fpu_req_ready = 1'b1;
    step();
    fpu_req_ready = 1'b0;
    respond(32'h5A5A);
    checkOutput("t4_r0_no_write", RegWriteW_fpu, 0);
    checkOutput("t4_r0_data", ResultW_fpu, 32'h5A5A);

    // Two ops to rd=9 in flight
    Rs1E = 6'd9;
    applyStimulus(1, 6'd9, 5'd9, 32'h91, 32'h0);
    step();
    applyStimulus(1, 6'd9, 5'd10, 32'h92, 32'h0);
    step();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t5_first_a", fpu_req_a, 32'h91);
    fpu_req_ready = 1'b1;
    step();
    checkOutput("t5_second_a", fpu_req_a, 32'h92);
    step();
    fpu_req_ready = 1'b0;
    #1;
    checkOutput("t5_all_out", fpu_req_valid, 0);
    respond(32'hAAAA);
    checkOutput("t5_wb1_rd", RdW_fpu, 9);
    checkOutput("t5_wb1_data", ResultW_fpu, 32'hAAAA);
    checkOutput("t5_still_pending", operand_invalid1, 1);
    respond(32'hBBBB);
    checkOutput("t5_wb2_we", RegWriteW_fpu, 1);
    checkOutput("t5_wb2_data", ResultW_fpu, 32'hBBBB);
    checkOutput("t5_cleared", operand_invalid1, 0);

    // Reset with full FIFO, 2 in flight and a response arriving
    applyStimulus(1, 6'd11, 5'd1, 32'h11, 32'h0);
    step();
    applyStimulus(1, 6'd12, 5'd2, 32'h12, 32'h0);
    step();
    applyStimulus(0, 0, 0, 0, 0);
    fpu_req_ready = 1'b1;
    step();
    step();
    fpu_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 6'(13 + i), 5'(i), 32'h0, 32'h0);
      step();
    end
    applyStimulus(0, 0, 0, 0, 0);
    Rs1E = 6'd11;
    Rs2E = 6'd13;
    #1;
    checkOutput("t6_full", full, 1);
    checkOutput("t6_inv1_pre", operand_invalid1, 1);
    checkOutput("t6_inv2_pre", operand_invalid2, 1);
    rst = 1'b1;
    respond(32'hCCCC);
    rst = 1'b0;
    #1;
    checkOutput("t6_full", full, 0);
    checkOutput("t6_req_valid", fpu_req_valid, 0);
    checkOutput("t6_regwrite", RegWriteW_fpu, 0);
    checkOutput("t6_rdw", RdW_fpu, 0);
    checkOutput("t6_result", ResultW_fpu, 0);
    checkOutput("t6_ovf", overflow_err, 0);
    checkOutput("t6_inv1", operand_invalid1, 0);
    checkOutput("t6_inv2", operand_invalid2, 0);
    step();
    checkOutput("t6_no_late_wb", RegWriteW_fpu, 0);

    // Response with nothing in flight
    respond(32'hEEEE);
    checkOutput("t7_orphan_ovf", overflow_err, 1);
    checkOutput("t7_orphan_no_wb", RegWriteW_fpu, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
